armleocpu_store_queue: RTL and testbench

- Buffers aligned, byte-lane-positioned store requests from the store generator and issues them one at a time as write transactions on the data bus.
- Sits between the execute stage's store generator and the data cache/bus port; decouples execute from bus write latency.
- Rejects misaligned stores with an error pulse; reports bus write errors.
- Provides a combinational hazard check so that loads can stall on pending stores to the same word.

---
 rtl/armleocpu_store_queue.sv | 142 ++++++++++++++
 tb/tb_armleocpu_store_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/armleocpu_store_queue.sv
// rtl/armleocpu_store_queue.sv - store buffer between the store generator and the data bus write port
module armleocpu_store_queue #(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             s_valid,
    output logic             s_ready,
    input  logic [31:0]      s_addr,
    input  logic [31:0]      s_data,
    input  logic [3:0]       s_mask,
    input  logic             s_missaligned,

    output logic             m_transaction,
    output logic [31:0]      m_address,
    output logic [31:0]      m_wdata,
    output logic [3:0]       m_wmask,
    input  logic             m_transaction_done,
    input  logic [1:0]       m_transaction_response,

    output logic             err_valid,
    output logic             err_misaligned,
    output logic [31:0]      err_addr,

    input  logic [31:0]      hazard_addr,
    output logic             hazard_hit,

    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [31:0]      addr_q [DEPTH];
    logic [31:0]      data_q [DEPTH];
    logic [3:0]       mask_q [DEPTH];

    logic [PTR_W-1:0] wptr_q;
    logic [PTR_W-1:0] rptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    logic             err_valid_q;
    logic             err_misaligned_q;
    logic [31:0]      err_addr_q;
    logic             pend_valid_q;
    logic [31:0]      pend_addr_q;

    logic             accept;
    logic             push;
    logic             mis_reject;
    logic             pop;
    logic             bus_err;
    logic [PTR_W-1:0] slot_off [DEPTH];
    logic             unused_hazard_lsb;

    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign m_transaction = !empty;
    assign s_ready       = (count_q < FULL_CNT) && !pend_valid_q;

    assign m_address = {addr_q[rptr_q][31:2], 2'b00};
    assign m_wdata   = data_q[rptr_q];
    assign m_wmask   = mask_q[rptr_q];

    assign accept     = s_valid && s_ready;
    assign mis_reject = accept && s_missaligned;
    assign push       = accept && !s_missaligned && (s_mask != 4'b0000);
    assign pop        = m_transaction && m_transaction_done;
    assign bus_err    = pop && (m_transaction_response != 2'b00);

    assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    assign err_valid      = err_valid_q;
    assign err_misaligned = err_misaligned_q;
    assign err_addr       = err_addr_q;

    assign unused_hazard_lsb = ^hazard_addr[1:0];

    // An entry is live when its distance from the head is below the occupancy count.
    always_comb begin
        hazard_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_off[i] = PTR_W'(i) - rptr_q;
            if ((CNT_W'(slot_off[i]) < count_q) && (addr_q[i][31:2] == hazard_addr[31:2])) begin
                hazard_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q           <= '0;
            rptr_q           <= '0;
            count_q          <= '0;
            err_valid_q      <= 1'b0;
            err_misaligned_q <= 1'b0;
            err_addr_q       <= '0;
            pend_valid_q     <= 1'b0;
            pend_addr_q      <= '0;
        end else begin
            count_q <= count_d;

            if (push) begin
                addr_q[wptr_q] <= s_addr;
                data_q[wptr_q] <= s_data;
                mask_q[wptr_q] <= s_mask;
                wptr_q         <= wptr_q + PTR_W'(1);
            end

            if (pop) begin
                rptr_q <= rptr_q + PTR_W'(1);
            end

            // Bus errors win; a colliding misaligned reject waits one cycle in the pending slot.
            if (bus_err) begin
                err_valid_q      <= 1'b1;
                err_misaligned_q <= 1'b0;
                err_addr_q       <= addr_q[rptr_q];
                if (mis_reject) begin
                    pend_valid_q <= 1'b1;
                    pend_addr_q  <= s_addr;
                end
            end else if (pend_valid_q) begin
                err_valid_q      <= 1'b1;
                err_misaligned_q <= 1'b1;
                err_addr_q       <= pend_addr_q;
                pend_valid_q     <= 1'b0;
            end else if (mis_reject) begin
                err_valid_q      <= 1'b1;
                err_misaligned_q <= 1'b1;
                err_addr_q       <= s_addr;
            end else begin
                err_valid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_armleocpu_store_queue.sv
// tb/tb_armleocpu_store_queue.sv - directed scenarios plus randomized run against a queue-based model
module tb_armleocpu_store_queue;

    localparam int DEPTH = 2;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst;
    logic             s_valid;
    logic             s_ready;
    logic [31:0]      s_addr;
    logic [31:0]      s_data;
    logic [3:0]       s_mask;
    logic             s_missaligned;
    logic             m_transaction;
    logic [31:0]      m_address;
    logic [31:0]      m_wdata;
    logic [3:0]       m_wmask;
    logic             m_transaction_done;
    logic [1:0]       m_transaction_response;
    logic             err_valid;
    logic             err_misaligned;
    logic [31:0]      err_addr;
    logic [31:0]      hazard_addr;
    logic             hazard_hit;
    logic             empty;
    logic [CNT_W-1:0] count;

    int vec = 0;
    int errs = 0;

    // Reference model: pending stores in FIFO order, unreported errors in report order.
    logic [31:0] mq_addr[$];
    logic [31:0] mq_data[$];
    logic [3:0]  mq_mask[$];
    logic        eq_mis[$];
    logic [31:0] eq_addr[$];
    logic        exp_err_valid;
    logic        exp_err_mis;
    logic [31:0] exp_err_addr;

    armleocpu_store_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_data(s_data),
        .s_mask(s_mask), .s_missaligned(s_missaligned),
        .m_transaction(m_transaction), .m_address(m_address), .m_wdata(m_wdata),
        .m_wmask(m_wmask), .m_transaction_done(m_transaction_done),
        .m_transaction_response(m_transaction_response),
        .err_valid(err_valid), .err_misaligned(err_misaligned), .err_addr(err_addr),
        .hazard_addr(hazard_addr), .hazard_hit(hazard_hit),
        .empty(empty), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        s_valid = 1'b0; s_addr = '0; s_data = '0; s_mask = '0; s_missaligned = 1'b0;
        m_transaction_done = 1'b0; m_transaction_response = 2'b00;
    endtask

    task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        s_valid = 1'b1; s_addr = a; s_data = d; s_mask = m; s_missaligned = 1'b0;
        step();
        s_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs(); hazard_addr = '0;
        rst = 1'b1; step(); step(); rst = 1'b0;
        vec++; if (empty !== 1'b1) begin errs++; $display("FAIL reset_empty got=%b exp=1", empty); end
        vec++; if (count !== CNT_W'(0)) begin errs++; $display("FAIL reset_count got=%0d exp=0", count); end
        vec++; if (s_ready !== 1'b1) begin errs++; $display("FAIL reset_ready got=%b exp=1", s_ready); end
        vec++; if (m_transaction !== 1'b0) begin errs++; $display("FAIL reset_trans got=%b exp=0", m_transaction); end
        vec++; if (err_valid !== 1'b0) begin errs++; $display("FAIL reset_errv got=%b exp=0", err_valid); end
        vec++; if (err_addr !== 32'h0) begin errs++; $display("FAIL reset_erra got=%h exp=0", err_addr); end
    endtask

    task automatic test_single_store();
        push_store(32'h1002, 32'hAB000000, 4'b1000);
        for (int i = 0; i < 3; i++) begin
            vec++; if (m_transaction !== 1'b1) begin errs++; $display("FAIL single_trans c%0d got=%b exp=1", i, m_transaction); end
            vec++; if (m_address !== 32'h1000) begin errs++; $display("FAIL single_addr c%0d got=%h exp=00001000", i, m_address); end
            vec++; if (m_wdata !== 32'hAB000000) begin errs++; $display("FAIL single_data c%0d got=%h exp=ab000000", i, m_wdata); end
            vec++; if (m_wmask !== 4'b1000) begin errs++; $display("FAIL single_mask c%0d got=%b exp=1000", i, m_wmask); end
            if (i == 2) m_transaction_done = 1'b1;
            step();
        end
        m_transaction_done = 1'b0;
        vec++; if (empty !== 1'b1) begin errs++; $display("FAIL single_empty got=%b exp=1", empty); end
        vec++; if (err_valid !== 1'b0) begin errs++; $display("FAIL single_errv got=%b exp=0", err_valid); end
    endtask

    task automatic test_fill();
        push_store(32'h4000, 32'h11111111, 4'b1111);
        vec++; if (count !== CNT_W'(1) || s_ready !== 1'b1) begin errs++; $display("FAIL fill_1 got cnt=%0d rdy=%b exp cnt=1 rdy=1", count, s_ready); end
        push_store(32'h4004, 32'h22222222, 4'b0011);
        vec++; if (count !== CNT_W'(2) || s_ready !== 1'b0) begin errs++; $display("FAIL fill_2 got cnt=%0d rdy=%b exp cnt=2 rdy=0", count, s_ready); end
        s_valid = 1'b1; s_addr = 32'h4008; s_data = 32'h33333333; s_mask = 4'b1100;
        step();
        vec++; if (count !== CNT_W'(2) || m_address !== 32'h4000) begin errs++; $display("FAIL fill_stall got cnt=%0d addr=%h exp cnt=2 addr=00004000", count, m_address); end
        m_transaction_done = 1'b1;
        step();
        m_transaction_done = 1'b0;
        vec++; if (count !== CNT_W'(1) || s_ready !== 1'b1 || m_address !== 32'h4004) begin errs++; $display("FAIL fill_pop got cnt=%0d rdy=%b addr=%h exp cnt=1 rdy=1 addr=00004004", count, s_ready, m_address); end
        step();
        s_valid = 1'b0;
        vec++; if (count !== CNT_W'(2) || m_wdata !== 32'h22222222) begin errs++; $display("FAIL fill_third got cnt=%0d data=%h exp cnt=2 data=22222222", count, m_wdata); end
        m_transaction_done = 1'b1;
        step();
        vec++; if (m_address !== 32'h4008 || m_wmask !== 4'b1100) begin errs++; $display("FAIL fill_wrap got addr=%h mask=%b exp addr=00004008 mask=1100", m_address, m_wmask); end
        step();
        m_transaction_done = 1'b0;
        vec++; if (empty !== 1'b1) begin errs++; $display("FAIL fill_drain got empty=%b exp=1", empty); end
    endtask

    task automatic test_misaligned_and_noop();
        s_valid = 1'b1; s_addr = 32'h2001; s_data = 32'h0000FF00; s_mask = 4'b0010; s_missaligned = 1'b1;
        step();
        idle_inputs();
        vec++; if (count !== CNT_W'(0)) begin errs++; $display("FAIL mis_count got=%0d exp=0", count); end
        vec++; if (err_valid !== 1'b1 || err_misaligned !== 1'b1 || err_addr !== 32'h2001) begin errs++; $display("FAIL mis_err got v=%b m=%b a=%h exp v=1 m=1 a=00002001", err_valid, err_misaligned, err_addr); end
        s_valid = 1'b1; s_addr = 32'h7000; s_mask = 4'b0000;
        step();
        idle_inputs();
        vec++; if (err_valid !== 1'b0 || count !== CNT_W'(0)) begin errs++; $display("FAIL noop got errv=%b cnt=%0d exp errv=0 cnt=0", err_valid, count); end
    endtask

    task automatic test_bus_error();
        push_store(32'h5000, 32'hDEADBEEF, 4'b1111);
        push_store(32'h5008, 32'hCAFEF00D, 4'b1111);
        m_transaction_done = 1'b1; m_transaction_response = 2'b11;
        step();
        m_transaction_done = 1'b0; m_transaction_response = 2'b00;
        vec++; if (err_valid !== 1'b1 || err_misaligned !== 1'b0 || err_addr !== 32'h5000) begin errs++; $display("FAIL buserr got v=%b m=%b a=%h exp v=1 m=0 a=00005000", err_valid, err_misaligned, err_addr); end
        vec++; if (m_transaction !== 1'b1 || m_address !== 32'h5008) begin errs++; $display("FAIL buserr_next got t=%b a=%h exp t=1 a=00005008", m_transaction, m_address); end
        m_transaction_done = 1'b1;
        step();
        m_transaction_done = 1'b0;
        vec++; if (err_valid !== 1'b0 || empty !== 1'b1) begin errs++; $display("FAIL buserr_done got errv=%b empty=%b exp errv=0 empty=1", err_valid, empty); end
    endtask

    task automatic test_simultaneous_errors();
        push_store(32'h6000, 32'h12345678, 4'b1111);
        m_transaction_done = 1'b1; m_transaction_response = 2'b01;
        s_valid = 1'b1; s_addr = 32'h6003; s_mask = 4'b0001; s_missaligned = 1'b1;
        step();
        idle_inputs();
        vec++; if (err_valid !== 1'b1 || err_misaligned !== 1'b0 || err_addr !== 32'h6000 || s_ready !== 1'b0) begin errs++; $display("FAIL dual_first got v=%b m=%b a=%h rdy=%b exp v=1 m=0 a=00006000 rdy=0", err_valid, err_misaligned, err_addr, s_ready); end
        step();
        vec++; if (err_valid !== 1'b1 || err_misaligned !== 1'b1 || err_addr !== 32'h6003 || s_ready !== 1'b1) begin errs++; $display("FAIL dual_second got v=%b m=%b a=%h rdy=%b exp v=1 m=1 a=00006003 rdy=1", err_valid, err_misaligned, err_addr, s_ready); end
        step();
        vec++; if (err_valid !== 1'b0) begin errs++; $display("FAIL dual_end got errv=%b exp=0", err_valid); end
    endtask

    task automatic test_hazard_reset();
        push_store(32'h3004, 32'h0BADF00D, 4'b1111);
        hazard_addr = 32'h3007; #1;
        vec++; if (hazard_hit !== 1'b1) begin errs++; $display("FAIL hazard_same got=%b exp=1", hazard_hit); end
        hazard_addr = 32'h3008; #1;
        vec++; if (hazard_hit !== 1'b0) begin errs++; $display("FAIL hazard_other got=%b exp=0", hazard_hit); end
        hazard_addr = 32'h3007;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vec++; if (m_transaction !== 1'b0 || count !== CNT_W'(0) || hazard_hit !== 1'b0) begin errs++; $display("FAIL hazard_reset got t=%b cnt=%0d hit=%b exp t=0 cnt=0 hit=0", m_transaction, count, hazard_hit); end
    endtask

    task automatic test_random();
        logic        acc, pop, exp_ready, exp_hit;
        logic        tmp_mis[$];
        logic [31:0] tmp_addr[$];
        for (int c = 0; c < 600; c++) begin
            rst                    = (c == 0) || ($urandom_range(0, 99) == 0);
            s_valid                = 1'($urandom_range(0, 1));
            s_addr                 = 32'h8000 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
            s_data                 = $urandom;
            s_mask                 = ($urandom_range(0, 5) == 0) ? 4'b0000 : 4'($urandom);
            s_missaligned          = ($urandom_range(0, 7) == 0);
            m_transaction_done     = 1'($urandom_range(0, 1));
            m_transaction_response = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hazard_addr            = 32'h8000 + ($urandom_range(0, 8) << 2) + $urandom_range(0, 3);
            #1;
            if (c > 0) begin
                exp_ready = (mq_addr.size() < DEPTH) && (eq_addr.size() == 0);
                exp_hit = 1'b0;
                foreach (mq_addr[k]) if (mq_addr[k][31:2] == hazard_addr[31:2]) exp_hit = 1'b1;
                vec++; if (count !== CNT_W'(mq_addr.size())) begin errs++; $display("FAIL rnd_count c%0d got=%0d exp=%0d", c, count, mq_addr.size()); end
                vec++; if (s_ready !== exp_ready) begin errs++; $display("FAIL rnd_ready c%0d got=%b exp=%b", c, s_ready, exp_ready); end
                vec++; if (m_transaction !== (mq_addr.size() != 0)) begin errs++; $display("FAIL rnd_trans c%0d got=%b exp=%b", c, m_transaction, mq_addr.size() != 0); end
                vec++; if (hazard_hit !== exp_hit) begin errs++; $display("FAIL rnd_hazard c%0d got=%b exp=%b", c, hazard_hit, exp_hit); end
                vec++; if (err_valid !== exp_err_valid) begin errs++; $display("FAIL rnd_errv c%0d got=%b exp=%b", c, err_valid, exp_err_valid); end
                if (mq_addr.size() != 0) begin
                    vec++; if (m_address !== {mq_addr[0][31:2], 2'b00} || m_wdata !== mq_data[0] || m_wmask !== mq_mask[0]) begin errs++; $display("FAIL rnd_head c%0d got a=%h d=%h m=%b exp a=%h d=%h m=%b", c, m_address, m_wdata, m_wmask, {mq_addr[0][31:2], 2'b00}, mq_data[0], mq_mask[0]); end
                end
                if (exp_err_valid) begin
                    vec++; if (err_misaligned !== exp_err_mis || err_addr !== exp_err_addr) begin errs++; $display("FAIL rnd_errinfo c%0d got m=%b a=%h exp m=%b a=%h", c, err_misaligned, err_addr, exp_err_mis, exp_err_addr); end
                end
            end
            if (rst) begin
                mq_addr.delete(); mq_data.delete(); mq_mask.delete(); eq_mis.delete(); eq_addr.delete();
                exp_err_valid = 1'b0; exp_err_mis = 1'b0; exp_err_addr = '0;
            end else begin
                acc = s_valid && (mq_addr.size() < DEPTH) && (eq_addr.size() == 0);
                pop = (mq_addr.size() != 0) && m_transaction_done;
                tmp_mis.delete(); tmp_addr.delete();
                if (pop && m_transaction_response != 2'b00) begin tmp_mis.push_back(1'b0); tmp_addr.push_back(mq_addr[0]); end
                foreach (eq_addr[k]) begin tmp_mis.push_back(eq_mis[k]); tmp_addr.push_back(eq_addr[k]); end
                if (acc && s_missaligned) begin tmp_mis.push_back(1'b1); tmp_addr.push_back(s_addr); end
                if (pop) begin void'(mq_addr.pop_front()); void'(mq_data.pop_front()); void'(mq_mask.pop_front()); end
                if (acc && !s_missaligned && s_mask != 4'b0000) begin
                    mq_addr.push_back(s_addr); mq_data.push_back(s_data); mq_mask.push_back(s_mask);
                end
                if (tmp_addr.size() != 0) begin
                    exp_err_valid = 1'b1; exp_err_mis = tmp_mis.pop_front(); exp_err_addr = tmp_addr.pop_front();
                end else begin
                    exp_err_valid = 1'b0;
                end
                eq_mis = tmp_mis; eq_addr = tmp_addr;
            end
            step();
        end
        idle_inputs(); rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_store();
        test_fill();
        test_misaligned_and_noop();
        test_bus_error();
        test_simultaneous_errors();
        test_hazard_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
